// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared state type, default sizes and 3x3 window offset tables
package median_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int DEF_W_LOG2 = 8;
  localparam int DEF_H_LOG2 = 8;

  // Window position of the last fetch and of the centre pixel.
  localparam logic [3:0] K_LAST   = 4'd8;
  localparam logic [3:0] K_CENTER = 4'd4;

  // Two-bit two's complement offsets, entry k at bits [2k+1:2k]; k scans row-major.
  localparam logic [17:0] WIN_I_TAB = {2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11};
  localparam logic [17:0] WIN_J_TAB = {2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11};

  function automatic logic signed [1:0] win_i(input logic [3:0] k);
    return $signed(WIN_I_TAB[{k, 1'b0} +: 2]);
  endfunction

  function automatic logic signed [1:0] win_j(input logic [3:0] k);
    return $signed(WIN_J_TAB[{k, 1'b0} +: 2]);
  endfunction

endpackage

// File: rtl/median_win_addr.sv
// rtl/median_win_addr.sv - clamped 3x3 window read address for pixel (x,y) at position k
module median_win_addr
  import median_pkg::*;
#(
  parameter int W_LOG2 = DEF_W_LOG2,
  parameter int H_LOG2 = DEF_H_LOG2
) (
  input  logic [W_LOG2-1:0]        x,
  input  logic [H_LOG2-1:0]        y,
  input  logic [3:0]               k,
  output logic [W_LOG2+H_LOG2-1:0] RADDR
);

  localparam logic signed [W_LOG2+1:0] X_MAX  = {2'b00, {W_LOG2{1'b1}}};
  localparam logic signed [H_LOG2+1:0] Y_MAX  = {2'b00, {H_LOG2{1'b1}}};
  localparam logic signed [W_LOG2+1:0] X_ZERO = '0;
  localparam logic signed [H_LOG2+1:0] Y_ZERO = '0;

  logic signed [1:0]        di;
  logic signed [1:0]        dj;
  logic signed [W_LOG2+1:0] sx;
  logic signed [H_LOG2+1:0] sy;
  logic [W_LOG2-1:0]        rx;
  logic [H_LOG2-1:0]        ry;

  // Offset each axis by the window position in two extra signed bits, then clamp to the frame.
  always_comb begin
    di = win_i(k);
    dj = win_j(k);
    sx = $signed({2'b00, x}) + $signed({{W_LOG2{dj[1]}}, dj});
    sy = $signed({2'b00, y}) + $signed({{H_LOG2{di[1]}}, di});
    if (sx < X_ZERO) begin
      rx = '0;
    end else if (sx > X_MAX) begin
      rx = '1;
    end else begin
      rx = sx[W_LOG2-1:0];
    end
    if (sy < Y_ZERO) begin
      ry = '0;
    end else if (sy > Y_MAX) begin
      ry = '1;
    end else begin
      ry = sy[H_LOG2-1:0];
    end
    RADDR = {ry, rx};
  end

endmodule

// File: rtl/median_window_seq.sv
// rtl/median_window_seq.sv - frame sequencer feeding 3x3 windows to a median filter; MEDIAN_SEQ_BORDER_COPY_EN copies border pixels
module median_window_seq
  import median_pkg::*;
#(
  parameter int W_LOG2 = DEF_W_LOG2,
  parameter int H_LOG2 = DEF_H_LOG2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     START,
  output logic [W_LOG2+H_LOG2-1:0] RADDR,
  input  logic [7:0]               RDATA,
  output logic [7:0]               DI,
  output logic                     DSI,
  input  logic [7:0]               MDO,
  input  logic                     MDSO,
  output logic [W_LOG2+H_LOG2-1:0] WADDR,
  output logic [7:0]               WDATA,
  output logic                     WE,
  output logic                     BUSY,
  output logic                     DONE
);

  state_t            state;
  state_t            next_state;
  logic [W_LOG2-1:0] x;
  logic [H_LOG2-1:0] y;
  logic [3:0]        k;
  logic [3:0]        k_addr;
  logic              dsi_q;
  logic              done_q;
  logic [7:0]        wdata_q;
  logic              x_last;
  logic              y_last;
  logic              last_pix;
  logic              border_pix;

  assign x_last   = (x == '1);
  assign y_last   = (y == '1);
  assign last_pix = x_last && y_last;

`ifdef MEDIAN_SEQ_BORDER_COPY_EN
  assign border_pix = (x == '0) || x_last || (y == '0) || y_last;
`else
  assign border_pix = 1'b0;
`endif

  assign DI    = RDATA;
  assign DSI   = dsi_q;
  assign DONE  = done_q;
  assign WADDR = {y, x};

  median_win_addr #(
    .W_LOG2(W_LOG2),
    .H_LOG2(H_LOG2)
  ) u_win_addr (
    .x    (x),
    .y    (y),
    .k    (k_addr),
    .RADDR(RADDR)
  );

  // Next state and per-state outputs; a copied border pixel reads only its own centre address.
  always_comb begin
    next_state = state;
    WE         = 1'b0;
    BUSY       = 1'b1;
    k_addr     = k;
    WDATA      = wdata_q;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        if (border_pix) begin
          k_addr     = K_CENTER;
          next_state = WRITE;
        end else if (k == K_LAST) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (MDSO) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        WE = 1'b1;
        if (border_pix) begin
          WDATA = RDATA;
        end
        next_state = last_pix ? IDLE : FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, pixel/window counters, DSI delay, result capture and DONE pulse.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      k       <= '0;
      dsi_q   <= 1'b0;
      done_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state  <= next_state;
      dsi_q  <= (state == FETCH) && !border_pix;
      done_q <= (state == WRITE) && last_pix;
      case (state)
        IDLE: begin
          if (START) begin
            x <= '0;
            y <= '0;
            k <= '0;
          end
        end
        FETCH: begin
          k <= (border_pix || (k == K_LAST)) ? 4'd0 : k + 4'd1;
        end
        WAIT: begin
          if (MDSO) begin
            wdata_q <= MDO;
          end
        end
        WRITE: begin
          if (border_pix) begin
            wdata_q <= RDATA;
          end
          x <= x + 1'b1;
          if (x_last) begin
            y <= y + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_seq.sv
// tb/tb_median_window_seq.sv - self-checking bench for median_window_seq on a 4x4 frame
module tb_median_window_seq;

  localparam int WL   = 2;
  localparam int HL   = 2;
  localparam int SIDE = 4;
  localparam int NPIX = 16;

  logic       CLK   = 1'b0;
  logic       nRST  = 1'b0;
  logic       START = 1'b0;
  logic [3:0] RADDR;
  logic [3:0] WADDR;
  logic [7:0] RDATA = 8'h00;
  logic [7:0] DI;
  logic [7:0] MDO;
  logic [7:0] WDATA;
  logic       DSI;
  logic       MDSO;
  logic       WE;
  logic       BUSY;
  logic       DONE;

  always #5 CLK = ~CLK;

  median_window_seq #(.W_LOG2(WL), .H_LOG2(HL)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .START(START),
    .RADDR(RADDR),
    .RDATA(RDATA),
    .DI   (DI),
    .DSI  (DSI),
    .MDO  (MDO),
    .MDSO (MDSO),
    .WADDR(WADDR),
    .WDATA(WDATA),
    .WE   (WE),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Source frame memory with one cycle read latency.
  logic [7:0] mem [NPIX];
  always @(posedge CLK) RDATA <= mem[RADDR];

  function automatic logic [7:0] med9(input logic [7:0] a_in [9]);
    logic [7:0] a [9];
    logic [7:0] t;
    a = a_in;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  // Median filter stub: collects DI while DSI, answers after a random delay.
  logic [7:0] win_q [$];
  int         win_cnt   = 0;
  bit         pending   = 0;
  int         delay     = 0;
  logic [7:0] pend_med  = 8'h00;
  logic       stub_mdso = 1'b0;
  logic [7:0] stub_mdo  = 8'h00;
  bit         noise_en  = 0;

  always @(posedge CLK) begin
    if (!nRST) begin
      win_q.delete();
      win_cnt   = 0;
      pending   = 0;
      stub_mdso <= 1'b0;
    end else begin
      stub_mdso <= 1'b0;
      if (DSI) begin
        win_q.push_back(DI);
        if (win_q.size() == 9) begin
          logic [7:0] w [9];
          for (int i = 0; i < 9; i++) w[i] = win_q[i];
          pend_med = med9(w);
          win_q.delete();
          pending = 1;
          delay   = $urandom_range(0, 3);
        end
        win_cnt = win_q.size();
      end
      if (pending) begin
        if (delay == 0) begin
          stub_mdso <= 1'b1;
          stub_mdo  <= pend_med;
          pending   = 0;
        end else begin
          delay--;
        end
      end
    end
  end

  assign MDSO = stub_mdso | (noise_en & (WE | ~BUSY | (DSI & (win_cnt < 8))));
  assign MDO  = stub_mdso ? stub_mdo : 8'hEE;

  // Reference model: expected write stream from clamped 3x3 medians.
  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q [$];
  int  exp_dsi = 0;

  function automatic int clampi(int v);
    return (v < 0) ? 0 : ((v > SIDE - 1) ? SIDE - 1 : v);
  endfunction

  function automatic bit is_border(int x, int y);
`ifdef MEDIAN_SEQ_BORDER_COPY_EN
    return (x == 0) || (y == 0) || (x == SIDE - 1) || (y == SIDE - 1);
`else
    return (x < 0) || (y < 0);
`endif
  endfunction

  task automatic build_expected();
    exp_q.delete();
    exp_dsi = 0;
    for (int y = 0; y < SIDE; y++)
      for (int x = 0; x < SIDE; x++) begin
        logic [7:0] w [9];
        logic [7:0] d;
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            w[n] = mem[clampi(y + dy) * SIDE + clampi(x + dx)];
            n++;
          end
        if (is_border(x, y)) begin
          d = mem[y * SIDE + x];
        end else begin
          d = med9(w);
          exp_dsi += 9;
        end
        exp_q.push_back('{addr: 4'(y * SIDE + x), data: d});
      end
  endtask

  // Output monitor: scoreboard on writes, DSI run lengths, DONE count.
  int         we_cnt   = 0;
  int         done_cnt = 0;
  int         dsi_cnt  = 0;
  int         dsi_run  = 0;
  logic [7:0] wr_seen [NPIX];

  always @(negedge CLK) begin
    if (!nRST) begin
      dsi_run = 0;
    end else begin
      if (DSI) begin
        dsi_run++;
        dsi_cnt++;
      end else if (dsi_run != 0) begin
        check("dsi_run_len", dsi_run, 9);
        dsi_run = 0;
      end
      if (WE) begin
        we_cnt++;
        wr_seen[WADDR] = WDATA;
        check("we_expected_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("waddr", WADDR, e.addr);
          check("wdata", WDATA, e.data);
        end
      end
      if (DONE) done_cnt++;
    end
  end

  int we0 = 0;
  int done0 = 0;
  int dsi0 = 0;

  task automatic begin_frame();
    build_expected();
    we0   = we_cnt;
    done0 = done_cnt;
    dsi0  = dsi_cnt;
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input bit spam);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 3000) begin
      @(negedge CLK);
      n++;
      if (DONE) begin
        seen  = 1;
        START = 1'b0;
      end else if (spam) begin
        START = 1'($urandom_range(0, 1));
      end
    end
    START = 1'b0;
    check({tag, "_done_seen"}, int'(seen), 1);
    repeat (2) @(negedge CLK);
    check({tag, "_we_count"}, we_cnt - we0, NPIX);
    check({tag, "_done_count"}, done_cnt - done0, 1);
    check({tag, "_dsi_cycles"}, dsi_cnt - dsi0, exp_dsi);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    check({tag, "_busy_after"}, BUSY, 0);
  endtask

  typedef struct {
    int exp_raddr;
    bit chk_raddr;
    bit exp_dsi;
    bit exp_busy;
  } vec_t;
  vec_t tab [11];

  initial begin
    tab[0]  = '{0, 1, 0, 1};
    tab[1]  = '{0, 1, 1, 1};
    tab[2]  = '{1, 1, 1, 1};
    tab[3]  = '{0, 1, 1, 1};
    tab[4]  = '{0, 1, 1, 1};
    tab[5]  = '{1, 1, 1, 1};
    tab[6]  = '{4, 1, 1, 1};
    tab[7]  = '{4, 1, 1, 1};
    tab[8]  = '{5, 1, 1, 1};
    tab[9]  = '{0, 0, 1, 1};
    tab[10] = '{0, 0, 0, 1};

    for (int i = 0; i < NPIX; i++) mem[i] = 8'h00;

    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_raddr", RADDR, 0);
    check("rst_waddr", WADDR, 0);
    check("rst_wdata", WDATA, 0);
    check("rst_dsi", DSI, 0);
    check("rst_we", WE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);
    check("idle_busy", BUSY, 0);

    // Random frame; first pixel traced cycle by cycle.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    begin_frame();
`ifdef MEDIAN_SEQ_BORDER_COPY_EN
    check("px00_raddr", RADDR, 0);
    check("px00_dsi", DSI, 0);
    @(negedge CLK);
    check("px00_we", WE, 1);
    check("px00_wdata", WDATA, mem[0]);
`else
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge CLK);
      if (tab[i].chk_raddr) check($sformatf("tab%0d_raddr", i), RADDR, tab[i].exp_raddr);
      check($sformatf("tab%0d_dsi", i), DSI, tab[i].exp_dsi);
      check($sformatf("tab%0d_busy", i), BUSY, tab[i].exp_busy);
    end
`endif
    finish_frame("rand0", 0);

    for (int i = 0; i < NPIX; i++) mem[i] = 8'h55;
    begin_frame();
    finish_frame("flat55", 0);

    for (int i = 0; i < NPIX; i++) mem[i] = 8'h10;
    mem[5] = 8'hFF;
    begin_frame();
    finish_frame("spike", 0);
    check("spike_addr5", wr_seen[5], 8'h10);

    // START spam and stray MDSO strobes outside WAIT.
    noise_en = 1;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    begin_frame();
    finish_frame("spam", 1);
    noise_en = 0;

    // Reset while fetching k=4 of the first window.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    begin_frame();
    repeat (4) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    check("abort_dsi", DSI, 0);
    check("abort_we", WE, 0);
    check("abort_busy", BUSY, 0);
    nRST = 1'b1;
    exp_q.delete();
    we0 = we_cnt;
    repeat (40) @(negedge CLK);
    check("abort_no_we", we_cnt - we0, 0);
    check("abort_stays_idle", BUSY, 0);

    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i * 16 + 3);
    begin_frame();
    finish_frame("ramp", 0);
    for (int i = 0; i < NPIX; i++) check($sformatf("ramp_px%0d", i), wr_seen[i], exp_ramp(i));

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
      begin_frame();
      finish_frame($sformatf("rand%0d", f + 1), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Ramp expectation: border copies source when copy mode is on, else the clamped median.
  function automatic int exp_ramp(int p);
    logic [7:0] w [9];
    int x;
    int y;
    int n;
    x = p % SIDE;
    y = p / SIDE;
    if (is_border(x, y)) return p * 16 + 3;
    n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        w[n] = 8'(clampi(y + dy) * SIDE * 16 + clampi(x + dx) * 16 + 3);
        n++;
      end
    return int'(med9(w));
  endfunction

endmodule

// File: doc/median_window_seq.md
MEDIAN_WINDOW_SEQ -- requirements
Module: median_window_seq

Interface
REQ-001 The block SHALL have parameter W_LOG2, default 8, meaning log2 of image width.
REQ-002 The block SHALL have parameter H_LOG2, default 8, meaning log2 of image height.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 nRST  in  1  reset, synchronous and active-low.
REQ-005 START  in  1  start one frame; sampled only in IDLE.
REQ-006 RADDR  out  W_LOG2+H_LOG2  source frame read address, {ry,rx}.
REQ-007 RDATA  in  8  source pixel; valid exactly one cycle after RADDR.
REQ-008 DI  out  8  pixel to the median filter; combinational copy of RDATA.
REQ-009 DSI  out  1  high for exactly 9 consecutive cycles per window.
REQ-010 MDO  in  8  median filter result.
REQ-011 MDSO  in  1  median filter result-valid strobe.
REQ-012 WADDR  out  W_LOG2+H_LOG2  result write address, {y,x}.
REQ-013 WDATA  out  8  result pixel.
REQ-014 WE  out  1  result write strobe; one cycle per pixel.
REQ-015 BUSY  out  1  frame in progress.
REQ-016 DONE  out  1  one-cycle pulse after the last write of a frame.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, WRITE.
- IDLE->FETCH on START=1; x=y=0; BUSY=1 on the next cycle.
REQ-018 FETCH SHALL last 9 cycles with k=0..8.
- RADDR = clamp(y+i), clamp(x+j), with i=k/3-1 and j=k%3-1.
- clamp maps -1 to 0 and max+1 to max.
REQ-019 DSI SHALL be the FETCH flag delayed by one cycle, so DI = window element k while DSI is high.
REQ-020 After FETCH the FSM SHALL enter WAIT, hold DSI=0, and leave WAIT on the first edge sampling MDSO=1, capturing MDO into WDATA.
REQ-021 MDSO SHALL be ignored outside WAIT.
REQ-022 A stall in WAIT SHALL be unbounded; there is no timeout.
REQ-023 WRITE SHALL last one cycle with WE=1 and WADDR={y,x}.
- Then x increments; on x wrap, y increments.
- If {y,x} was the last pixel, DONE=1, BUSY=0, next state IDLE.
- Otherwise next state FETCH.
REQ-024 START SHALL be ignored while BUSY=1.
REQ-025 Counters SHALL wrap modulo 2^W_LOG2 and 2^H_LOG2.
- Clamping SHALL use signed compare, with no address overflow at the borders.

Reset
REQ-026 While nRST=0 at a rising edge, the block SHALL:
- enter IDLE;
- drive RADDR, WADDR, WDATA = 0 and DSI, WE, BUSY, DONE = 0 from the next cycle;
- clear x, y and k.
REQ-027 Reset mid-frame SHALL abort with no further WE, and SHALL need a new START to restart.

Configuration
REQ-028 Macro MEDIAN_SEQ_BORDER_COPY_EN SHALL select border handling.
- Defined: pixels with x=0, x=max, y=0 or y=max skip the window.
- Instead FETCH issues one read at {y,x}, DSI stays 0, no WAIT, and WDATA = RDATA in WRITE.
- Undefined: every pixel goes through the median filter with clamped window.

Structure
REQ-029 Package median_pkg SHALL hold:
- the state enum;
- default W_LOG2/H_LOG2;
- the window-offset tables (i,j per k).
REQ-030 Clamped address generation SHALL be sub-module median_win_addr, combinational, with inputs x, y, k and output RADDR.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset: hold nRST=0 for 3 cycles -> all outputs 0, state IDLE.
- 4x4 (W_LOG2=H_LOG2=2), all 0x55 -> 16 WE pulses, WDATA=0x55, WADDR 0..15 in order, one DONE.
- Pixel (0,0), macro undefined -> RADDR sequence 0,0,1,0,0,1,4,4,5; DSI high 9 cycles.
- 4x4 at 0x10 with (1,1)=0xFF, model median stub -> WDATA at WADDR 5 = 0x10.
- START pulsed mid-frame -> ignored; nRST=0 during FETCH k=4 -> DSI=0 next cycle, no WE.
- Macro defined, 4x4 ramp -> the 12 border pixels written as source values with no DSI; the 4 interior pixels filtered.
